// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_MULT  = 2'b01,
      OP_DIVU  = 2'b10,
      OP_DIV   = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   localparam int ITER = 32;
   localparam int CW   = $clog2(ITER);

   // Magnitude of a two's-complement value when the op is signed, raw otherwise.
   function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
      return (is_signed && v[31]) ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
// Multiply acc = {0, hi[31:0], multiplier}; divide acc = {rem[32:0], dividend/quotient}.
module muldiv_step (
   input  logic        is_div,
   input  logic [31:0] opnd,
   input  logic [64:0] acc_in,
   output logic [64:0] acc_out
);

   logic [32:0] sum;
   logic [32:0] shifted;
   logic [32:0] diff;

   always_comb begin
      sum     = acc_in[64:32] + (acc_in[0] ? {1'b0, opnd} : 33'd0);
      shifted = {acc_in[63:32], acc_in[31]};
      diff    = shifted - {1'b0, opnd};
      if (is_div) begin
         // A clear borrow bit means the trial subtraction fits: keep it, quotient bit 1.
         if (!diff[32]) acc_out = {diff, acc_in[30:0], 1'b1};
         else           acc_out = {shifted, acc_in[30:0], 1'b0};
      end else begin
         acc_out = {1'b0, sum, acc_in[31:1]};
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply/divide with start/busy/done handshake and HI/LO result registers.
// Optional MULDIV_DIVZERO_EN: early divide-by-zero completion and a DivZero flag output.
module mult_div_unit
   import muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [1:0]  Op,
   input  logic        Start,
   output logic        Busy,
   output logic        Done,
   output logic [31:0] HI,
   output logic [31:0] LO
`ifdef MULDIV_DIVZERO_EN
   ,
   output logic        DivZero
`endif
);

   state_t          state, state_nxt;
   logic [CW-1:0]   count;
   op_t             op_q;
   logic [31:0]     opnd_q;
   logic [31:0]     a_raw_q;
   logic [64:0]     acc_q, acc_nxt;
   logic            neg_q, neg_r, dz_q;
   logic            op_is_div;
   logic [31:0]     a_mag, b_mag;
   logic            in_dz;
   logic [63:0]     res;

   assign op_is_div = (op_q == OP_DIVU) || (op_q == OP_DIV);
   assign a_mag     = mag32(A, Op[0]);
   assign b_mag     = mag32(B, Op[0]);
   assign in_dz     = Op[1] && (B == 32'd0);
   assign Busy      = (state != IDLE);

   muldiv_step u_step (
      .is_div  (op_is_div),
      .opnd    (opnd_q),
      .acc_in  (acc_q),
      .acc_out (acc_nxt)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (Start) begin
`ifdef MULDIV_DIVZERO_EN
            state_nxt = in_dz ? FIX : RUN;
`else
            state_nxt = RUN;
`endif
         end
         RUN:     if (count == CW'(ITER - 1)) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Sign fix-up: whole product, or quotient and remainder independently.
   always_comb begin
      res = acc_q[63:0];
      if (dz_q) begin
         res = {a_raw_q, 32'hFFFF_FFFF};
      end else if (op_is_div) begin
         res = {(neg_r ? -acc_q[63:32] : acc_q[63:32]),
                (neg_q ? -acc_q[31:0]  : acc_q[31:0])};
      end else if (neg_q) begin
         res = -acc_q[63:0];
      end
   end

   // NOTE: the whole datapath is reset, so an aborted op leaves no stale operands behind.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count   <= '0;
         op_q    <= OP_MULTU;
         opnd_q  <= '0;
         a_raw_q <= '0;
         acc_q   <= '0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         dz_q    <= 1'b0;
         Done    <= 1'b0;
         HI      <= '0;
         LO      <= '0;
`ifdef MULDIV_DIVZERO_EN
         DivZero <= 1'b0;
`endif
      end else begin
         Done <= 1'b0;
         case (state)
            IDLE: if (Start) begin
               op_q    <= op_t'(Op);
               a_raw_q <= A;
               dz_q    <= in_dz;
               neg_q   <= Op[0] & (A[31] ^ B[31]);
               neg_r   <= Op[0] & A[31];
               count   <= '0;
               opnd_q  <= Op[1] ? b_mag : a_mag;
               acc_q   <= {33'd0, (Op[1] ? a_mag : b_mag)};
            end
            RUN: begin
               acc_q <= acc_nxt;
               count <= count + 1'b1;
            end
            FIX: begin
               HI   <= res[63:32];
               LO   <= res[31:0];
               Done <= 1'b1;
`ifdef MULDIV_DIVZERO_EN
               DivZero <= dz_q;
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases, handshake scenarios and
// randomized ops against an arithmetic reference model. Honours MULDIV_DIVZERO_EN.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] A, B;
   logic [1:0]  Op;
   logic        Start;
   logic        Busy, Done;
   logic [31:0] HI, LO;
`ifdef MULDIV_DIVZERO_EN
   logic        DivZero;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   mult_div_unit dut (
      .clk     (clk),
      .reset   (reset),
      .A       (A),
      .B       (B),
      .Op      (Op),
      .Start   (Start),
      .Busy    (Busy),
      .Done    (Done),
      .HI      (HI),
      .LO      (LO)
`ifdef MULDIV_DIVZERO_EN
      ,
      .DivZero (DivZero)
`endif
   );

   always #5 clk = ~clk;

   // Reference: {HI, LO} from plain arithmetic on 64-bit integers.
   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb, q, r;
      longint unsigned ua, ub, p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      if (op[1] && b == 32'd0) return {a, 32'hFFFF_FFFF};
      case (op)
         2'b00: begin p = ua * ub; return p; end
         2'b01: begin q = sa * sb; return q; end
         2'b10: return {ua % ub, 32'd0} | {32'd0, ua / ub};
         default: begin
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
      endcase
   endfunction

   function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
`ifdef MULDIV_DIVZERO_EN
      if (op[1] && b == 32'd0) return 1;
`endif
      return 33;
   endfunction

   // Drive a request sampled at the next rising edge, then scramble inputs.
   task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      A = a; B = b; Op = op; Start = 1'b1;
      @(posedge clk); #1;
      Start = 1'b0; A = $urandom; B = $urandom; Op = 2'($urandom);
   endtask

   // Cycles after the start edge until Done is observed (bounded).
   task automatic wait_done(output int n, output bit busy_ok);
      n = 0;
      busy_ok = 1'b1;
      while (!Done && n < 60) begin
         if (!Busy) busy_ok = 1'b0;
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
      logic [63:0] exp;
      int          n, lat;
      bit          busy_ok;
      exp = model(op, a, b);
      lat = exp_lat(op, b);
      start_op(op, a, b);
      wait_done(n, busy_ok);
      n_checks++;
      if (n !== lat) begin
         n_fail++; $display("FAIL %s latency: got %0d cycles, expected %0d", name, n, lat);
      end
      n_checks++;
      if (busy_ok !== 1'b1 || Busy !== 1'b0) begin
         n_fail++; $display("FAIL %s busy: busy-held=%0b busy-at-done=%0b, expected 1/0", name, busy_ok, Busy);
      end
      n_checks++;
      if ({HI, LO} !== exp) begin
         n_fail++; $display("FAIL %s result: got HI=%h LO=%h, expected HI=%h LO=%h", name, HI, LO, exp[63:32], exp[31:0]);
      end
`ifdef MULDIV_DIVZERO_EN
      n_checks++;
      if (DivZero !== (op[1] && b == 32'd0)) begin
         n_fail++; $display("FAIL %s divzero: got %b expected %b", name, DivZero, (op[1] && b == 32'd0));
      end
`endif
      @(posedge clk); #1;
      n_checks++;
      if (Done !== 1'b0 || {HI, LO} !== exp) begin
         n_fail++; $display("FAIL %s pulse/hold: Done=%b HI=%h LO=%h, expected Done=0 and held result", name, Done, HI, LO);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; Start = 1'b0; A = '0; B = '0; Op = '0;
      #2;
      n_checks++;
      if ({Busy, Done, HI, LO} !== 66'd0) begin
         n_fail++; $display("FAIL reset: Busy=%b Done=%b HI=%h LO=%h, expected all zero", Busy, Done, HI, LO);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({Busy, Done} !== 2'b00) begin
         n_fail++; $display("FAIL reset_idle: Busy=%b Done=%b, expected 0/0", Busy, Done);
      end
   endtask

   task automatic test_directed();
      do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
      do_op(2'b01, 32'hFFFF_FFFD, 32'd7,         "mult_neg3x7");
      do_op(2'b11, 32'hFFFF_FFF9, 32'd2,         "div_neg7by2");
      do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
      do_op(2'b10, 32'd100,       32'd0,         "divu_by_zero");
      do_op(2'b11, 32'hFFFF_FF9C, 32'd0,         "div_by_zero_neg");
      do_op(2'b10, 32'hFFFF_FFFF, 32'd1,         "divu_by_one");
   endtask

   task automatic test_random();
      logic [1:0]  op;
      logic [31:0] a, b;
      for (int i = 0; i < 30; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: a = 32'h8000_0000;
            2: b = 32'hFFFF_FFFF;
            3: b = $urandom_range(1, 15);
            default: ;
         endcase
         do_op(op, a, b, "random");
      end
   endtask

   task automatic test_start_ignored();
      logic [63:0] exp;
      int          n;
      exp = model(2'b01, 32'h1234_5678, 32'hFEDC_BA98);
      start_op(2'b01, 32'h1234_5678, 32'hFEDC_BA98);
      n = 0;
      while (!Done && n < 60) begin
         if (n == 5) begin Start = 1'b1; A = 32'd3; B = 32'd5; Op = 2'b00; end
         if (n == 6) Start = 1'b0;
         @(posedge clk); #1;
         n++;
      end
      n_checks++;
      if (n !== 33 || {HI, LO} !== exp) begin
         n_fail++; $display("FAIL start_ignored: latency %0d HI=%h LO=%h, expected 33 HI=%h LO=%h", n, HI, LO, exp[63:32], exp[31:0]);
      end
      @(posedge clk); #1;
      n_checks++;
      if ({Busy, Done} !== 2'b00) begin
         n_fail++; $display("FAIL start_ignored_idle: Busy=%b Done=%b, expected 0/0", Busy, Done);
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] exp1, exp2;
      int          n;
      bit          busy_ok;
      exp1 = model(2'b10, 32'd1000, 32'd7);
      exp2 = model(2'b00, 32'hDEAD_BEEF, 32'h0000_1001);
      start_op(2'b10, 32'd1000, 32'd7);
      wait_done(n, busy_ok);
      n_checks++;
      if (n !== 33 || {HI, LO} !== exp1) begin
         n_fail++; $display("FAIL b2b_first: latency %0d HI=%h LO=%h, expected 33 HI=%h LO=%h", n, HI, LO, exp1[63:32], exp1[31:0]);
      end
      A = 32'hDEAD_BEEF; B = 32'h0000_1001; Op = 2'b00; Start = 1'b1;
      @(posedge clk); #1;
      Start = 1'b0; A = $urandom; B = $urandom;
      wait_done(n, busy_ok);
      n_checks++;
      if (n !== 33 || busy_ok !== 1'b1 || {HI, LO} !== exp2) begin
         n_fail++; $display("FAIL b2b_second: latency %0d busy-held=%0b HI=%h LO=%h, expected 33/1 HI=%h LO=%h",
                            n, busy_ok, HI, LO, exp2[63:32], exp2[31:0]);
      end
   endtask

   task automatic test_reset_mid_op();
      bit seen;
      start_op(2'b01, 32'h0000_1234, 32'h0000_5678);
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      n_checks++;
      if ({Busy, Done, HI, LO} !== 66'd0) begin
         n_fail++; $display("FAIL reset_mid: Busy=%b Done=%b HI=%h LO=%h, expected all zero", Busy, Done, HI, LO);
      end
`ifdef MULDIV_DIVZERO_EN
      n_checks++;
      if (DivZero !== 1'b0) begin
         n_fail++; $display("FAIL reset_mid_divzero: got %b expected 0", DivZero);
      end
`endif
      repeat (3) @(negedge clk);
      reset = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (Done || Busy) seen = 1'b1;
      end
      n_checks++;
      if (seen !== 1'b0) begin
         n_fail++; $display("FAIL reset_abort: got Done/Busy activity=%b, expected none", seen);
      end
      do_op(2'b11, 32'h7FFF_FFFF, 32'hFFFF_FFF0, "after_reset");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_start_ignored();
      test_back_to_back();
      test_reset_mid_op();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
